// File: rtl/clk_divider_prog.sv
// clk_divider_prog: programmable clock-enable divider with tick and glitch-free config apply
module clk_divider_prog #(
   parameter int               CNT_W      = 32,
   parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(100000000),
   parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(50000000)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             pending,
   output logic             clk_div,
   output logic             tick
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
   logic [CNT_W-1:0] sh_period_q, sh_period_d, sh_high_q, sh_high_d;
   logic pending_q, pending_d, cfg_err_q, cfg_err_d;
   logic clk_div_q, clk_div_d, tick_q, tick_d;
   logic accept, cfg_ok, wrap, apply;
   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   // next state: run exactly while en is sampled high
   always_comb begin
      state_d = en ? RUN : IDLE;
   end
   // next counter, settings, handshake and registered outputs
   always_comb begin
      accept      = cfg_valid & ~pending_q;
      cfg_ok      = (cfg_high != '0) & (cfg_high < cfg_period);
      wrap        = (state_q == RUN) & (cnt_q == period_q - CNT_W'(1));
      apply       = pending_q & (wrap | (state_q == IDLE) | ~en);
      cnt_d       = (state_q == RUN && en && !wrap) ? cnt_q + CNT_W'(1) : '0;
      period_d    = apply ? sh_period_q : period_q;
      high_d      = apply ? sh_high_q : high_q;
      sh_period_d = (accept & cfg_ok) ? cfg_period : sh_period_q;
      sh_high_d   = (accept & cfg_ok) ? cfg_high : sh_high_q;
      pending_d   = (accept & cfg_ok) | (pending_q & ~apply);
      cfg_err_d   = accept & ~cfg_ok;
      clk_div_d   = en & (cnt_d < high_d);
      tick_d      = en & (cnt_d == '0);
   end
   // datapath registers; reset drops any shadow config
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         period_q    <= DEF_PERIOD;
         high_q      <= DEF_HIGH;
         sh_period_q <= DEF_PERIOD;
         sh_high_q   <= DEF_HIGH;
         pending_q   <= 1'b0;
         cfg_err_q   <= 1'b0;
         clk_div_q   <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         high_q      <= high_d;
         sh_period_q <= sh_period_d;
         sh_high_q   <= sh_high_d;
         pending_q   <= pending_d;
         cfg_err_q   <= cfg_err_d;
         clk_div_q   <= clk_div_d;
         tick_q      <= tick_d;
      end
   end
   assign cfg_ready = ~pending_q;
   assign pending   = pending_q;
   assign cfg_err   = cfg_err_q;
   assign clk_div   = clk_div_q;
   assign tick      = tick_q;
endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog: directed and random checks against a cycle-level reference model
module tb_clk_divider_prog;
   localparam int W = 8;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, cfg_valid = 1'b0;
   logic [W-1:0] cfg_period = '0, cfg_high = '0;
   logic cfg_ready, cfg_err, pending, clk_div, tick;
   int checks = 0, errors = 0;
   int m_run = 0, m_pos = 0, m_per = 0, m_hi = 0, m_err = 0;
   int sh_p[$], sh_h[$];

   clk_divider_prog #(.CNT_W(W), .DEF_PERIOD(8'd10), .DEF_HIGH(8'd5)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid),
      .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_ready(cfg_ready),
      .cfg_err(cfg_err), .pending(pending), .clk_div(clk_div), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   // model: period position counted from the first cycle of the period
   task automatic step();
      int acc, ok, wrap, apply, npos;
      @(posedge clk);
      if (!rst_n) begin
         m_run = 0; m_pos = 0; m_per = 10; m_hi = 5; m_err = 0;
         sh_p.delete(); sh_h.delete();
      end else begin
         acc   = cfg_valid && sh_p.size() == 0;
         ok    = int'(cfg_period) >= 2 && int'(cfg_high) >= 1 && int'(cfg_high) <= int'(cfg_period) - 1;
         wrap  = m_run && en && m_pos == m_per - 1;
         apply = sh_p.size() != 0 && (!m_run || !en || wrap);
         m_err = acc && !ok;
         npos  = (m_run && en) ? (wrap ? 0 : m_pos + 1) : 0;
         if (apply) begin
            m_per = sh_p.pop_front();
            m_hi  = sh_h.pop_front();
         end
         if (acc && ok) begin
            sh_p.push_back(int'(cfg_period));
            sh_h.push_back(int'(cfg_high));
         end
         m_run = en;
         m_pos = npos;
      end
      #1;
      chk("clk_div", clk_div, m_run != 0 && m_pos < m_hi);
      chk("tick", tick, m_run != 0 && m_pos == 0);
      chk("pending", pending, sh_p.size() != 0);
      chk("cfg_ready", cfg_ready, sh_p.size() == 0);
      chk("cfg_err", cfg_err, m_err != 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic offer(input int p, input int h);
      cfg_valid = 1'b1; cfg_period = W'(p); cfg_high = W'(h);
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_pos(input int p);
      bit f = 0;
      for (int i = 0; i < 600 && !f; i++) begin
         if (m_run != 0 && m_pos == p) f = 1;
         else step();
      end
      checks++;
      assert (f) else begin
         errors++;
         $error("FAIL wait_pos observed=timeout expected=pos %0d", p);
      end
   endtask

   initial begin
      run(2);
      rst_n = 1'b1;
      run(2);
      en = 1'b1;
      run(25);
      wait_pos(2);
      offer(4, 1);
      run(30);
      offer(1, 0); run(3);
      offer(5, 0); run(3);
      offer(5, 5); run(3);
      offer(0, 0); run(3);
      wait_pos(m_per - 1);
      offer(6, 3);
      run(20);
      wait_pos(2);
      en = 1'b0;
      run(3);
      offer(9, 4);
      run(3);
      en = 1'b1;
      run(20);
      wait_pos(0);
      offer(12, 6);
      run(2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      run(25);
      wait_pos(0);
      offer(255, 254);
      run(600);
      offer(3, 2);
      wait_pos(2);
      en = 1'b0;
      step();
      en = 1'b1;
      run(10);
      for (int i = 0; i < 3000; i++) begin
         int p;
         rst_n     = $urandom_range(0, 199) != 0;
         en        = $urandom_range(0, 19) != 0;
         cfg_valid = $urandom_range(0, 7) == 0;
         p          = $urandom_range(0, 12);
         cfg_period = W'(p);
         cfg_high   = W'($urandom_range(0, p + 1));
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
